// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Groups the signals between the two writeback sources, the decode stage and
//   the register-file write port.
//
//   ALU source     : alu_valid, alu_addr[4:0], alu_data[15:0] -> alu_ready
//   Load source    : mem_valid, mem_addr[4:0], mem_data[15:0] -> mem_ready
//   Decode stage   : rR1_addr, rR2_addr -> r1_pending, r2_pending
//   Register file  : write_en, wR_addr[4:0], write_data[15:0]
//
//   master : the surrounding pipeline (drives requests and read addresses)
//   slave  : the arbiter (drives handshakes, pending flags and the write port)
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [15:0] alu_data;
    logic        alu_ready;

    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;

    logic [4:0]  rR1_addr;
    logic [4:0]  rR2_addr;
    logic        r1_pending;
    logic        r2_pending;

    logic        write_en;
    logic [4:0]  wR_addr;
    logic [15:0] write_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        output rR1_addr, rR2_addr,
        input  r1_pending, r2_pending,
        input  write_en, wR_addr, write_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        input  rR1_addr, rR2_addr,
        output r1_pending, r2_pending,
        output write_en, wR_addr, write_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single write port of the 32x16 register file between the ALU
//   writeback (priority, unbuffered) and the load writeback (buffered in a
//   small FIFO). The write port is driven from a registered output stage.
//   A starvation counter forces one FIFO entry out after STARVE_LIMIT cycles
//   of the head being passed over. ALU writes to a register that still has a
//   buffered load are held off so same-register writes stay in order.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   wb     : regfile_wb_arbiter_if.slave (ALU/load requests, decode read
//            addresses and pending flags, register-file write port)
//
// Parameters
//   FIFO_DEPTH   : load-writeback buffer entries (power of 2, >= 2)
//   STARVE_LIMIT : cycles the FIFO head may wait before a forced drain (>= 1)
//
// Optional build macro
//   REGFILE_WB_R0_DISCARD_EN : writes to register 0 are accepted but dropped;
//   register 0 never shows as pending and never blocks the ALU.
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   wb
);

`ifdef REGFILE_WB_R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    // An address that participates in writes, hazards and pending checks.
    function automatic logic addr_live(input logic [4:0] a);
        return !(R0_DISCARD && (a == 5'd0));
    endfunction

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;

    logic [4:0]          fifo_addr [FIFO_DEPTH];
    logic [15:0]         fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] entry_vld;
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;

    logic                full, empty;
    logic                push, pop;
    logic                alu_rdy, alu_issue;
    logic                alu_hit, r1_hit, r2_hit;

    logic                vld_p1;
    logic [4:0]          addr_p1;
    logic [15:0]         data_p1;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Ready comes from the registered occupancy only, so a pop in the same
    // cycle does not open the slot until the next cycle.
    assign wb.mem_ready = !full;
    assign push         = wb.mem_valid && !full && addr_live(wb.mem_addr);

    // Address compares against every buffered entry.
    always_comb begin
        alu_hit = 1'b0;
        r1_hit  = 1'b0;
        r2_hit  = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld[i]) begin
                if (fifo_addr[i] == wb.alu_addr) alu_hit = 1'b1;
                if (fifo_addr[i] == wb.rR1_addr) r1_hit  = 1'b1;
                if (fifo_addr[i] == wb.rR2_addr) r2_hit  = 1'b1;
            end
        end
    end

    assign wb.r1_pending = addr_live(wb.rR1_addr) &&
                           (r1_hit || (vld_p1 && (addr_p1 == wb.rR1_addr)));
    assign wb.r2_pending = addr_live(wb.rR2_addr) &&
                           (r2_hit || (vld_p1 && (addr_p1 == wb.rR2_addr)));

    // Arbitration FSM: ALU wins the output stage in NORMAL; DRAIN forces one
    // FIFO entry out after the head has been passed over too long.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        alu_rdy   = 1'b0;
        alu_issue = 1'b0;
        pop       = 1'b0;
        case (state)
            NORMAL: begin
                alu_rdy   = !(alu_hit && addr_live(wb.alu_addr));
                // A discarded register-0 write leaves the output stage free.
                alu_issue = wb.alu_valid && alu_rdy && addr_live(wb.alu_addr);
                pop       = !empty && !alu_issue;
                if (pop || empty) begin
                    wait_nxt = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = DRAIN;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            DRAIN: begin
                pop       = !empty;
                wait_nxt  = '0;
                state_nxt = NORMAL;
            end
            default: begin
                state_nxt = NORMAL;
                wait_nxt  = '0;
            end
        endcase
    end

    assign wb.alu_ready = alu_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // FIFO control; pointers wrap naturally since FIFO_DEPTH is a power of 2.
    // A simultaneous push and pop never hit the same slot (push needs !full,
    // pop needs !empty).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            entry_vld <= '0;
        end else begin
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                entry_vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                entry_vld[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wb.mem_addr;
            fifo_data[wr_ptr] <= wb.mem_data;
        end
    end

    // ---- stage p1: registered register-file write port ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= alu_issue || pop;
            if (alu_issue) begin
                addr_p1 <= wb.alu_addr;
                data_p1 <= wb.alu_data;
            end else if (pop) begin
                addr_p1 <= fifo_addr[rd_ptr];
                data_p1 <= fifo_data[rd_ptr];
            end
        end
    end

    assign wb.write_en   = vld_p1;
    assign wb.wR_addr    = addr_p1;
    assign wb.write_data = data_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=8).
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m;
    logic acc;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_addr  = 5'd0;
        bus.alu_data  = 16'h0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 5'd0;
        bus.mem_data  = 16'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        bus.rR1_addr = 5'd0;
        bus.rR2_addr = 5'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_write_en",   32'(bus.write_en),   0);
        check_val("rst_wR_addr",    32'(bus.wR_addr),    0);
        check_val("rst_write_data", 32'(bus.write_data), 0);
        check_val("rst_mem_ready",  32'(bus.mem_ready),  1);
        check_val("rst_alu_ready",  32'(bus.alu_ready),  1);
        reset = 1'b1;

        // ALU write r3 = 0x1234
        step();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 16'h1234;
        @(negedge clk);
        check_val("t1_alu_ready", 32'(bus.alu_ready), 1);
        check_val("t1_pre_wen",   32'(bus.write_en),  0);
        step();
        idle_inputs();
        @(negedge clk);
        check_val("t1_wen",   32'(bus.write_en),   1);
        check_val("t1_waddr", 32'(bus.wR_addr),    3);
        check_val("t1_wdata", 32'(bus.write_data), 32'h1234);
        step();
        @(negedge clk);
        check_val("t1_idle_wen",  32'(bus.write_en),   0);
        check_val("t1_hold_addr", 32'(bus.wR_addr),    3);
        check_val("t1_hold_data", 32'(bus.write_data), 32'h1234);

        // Single load write r7 = 0xBEEF
        step();
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd7; bus.mem_data = 16'hBEEF;
        bus.rR1_addr = 5'd7; bus.rR2_addr = 5'd7;
        @(negedge clk);
        check_val("t2_mem_ready", 32'(bus.mem_ready),  1);
        check_val("t2_pend_pre",  32'(bus.r1_pending), 0);
        step();
        idle_inputs();
        @(negedge clk);
        check_val("t2_pend_fifo", 32'(bus.r1_pending), 1);
        check_val("t2_wen_n",     32'(bus.write_en),   0);
        step();
        @(negedge clk);
        check_val("t2_wen",       32'(bus.write_en),   1);
        check_val("t2_waddr",     32'(bus.wR_addr),    7);
        check_val("t2_wdata",     32'(bus.write_data), 32'hBEEF);
        check_val("t2_pend_out",  32'(bus.r1_pending), 1);
        check_val("t2_pend2_out", 32'(bus.r2_pending), 1);
        step();
        @(negedge clk);
        check_val("t2_wen_after",  32'(bus.write_en),   0);
        check_val("t2_pend_after", 32'(bus.r1_pending), 0);
        bus.rR1_addr = 5'd0; bus.rR2_addr = 5'd0;

        // Five loads r10..r14 against a continuous ALU stream to r1:
        // forced drains land every 9th cycle starting at cycle 9.
        step();
        m = 0;
        for (int cyc = 0; cyc < 47; cyc++) begin
            bus.mem_valid = (m < 5);
            bus.mem_addr  = 5'(10 + m);
            bus.mem_data  = 16'hA000 + 16'(m);
            bus.alu_valid = 1'b1;
            bus.alu_addr  = 5'd1;
            bus.alu_data  = 16'h0100 + 16'(cyc);
            @(negedge clk);
            check_val($sformatf("t3_alu_ready_c%0d", cyc), 32'(bus.alu_ready),
                      (cyc >= 9 && (cyc % 9) == 0) ? 0 : 1);
            if (cyc == 1) begin
                check_val("t3_alu_waddr", 32'(bus.wR_addr),    1);
                check_val("t3_alu_wdata", 32'(bus.write_data), 32'h0100);
            end
            if (cyc == 4)  check_val("t3_full_c4",   32'(bus.mem_ready), 0);
            if (cyc == 10) check_val("t3_open_c10",  32'(bus.mem_ready), 1);
            if (cyc == 11) check_val("t3_full_c11",  32'(bus.mem_ready), 0);
            if (cyc == 19) check_val("t3_open_c19",  32'(bus.mem_ready), 1);
            if (cyc >= 10 && (cyc % 9) == 1) begin
                check_val($sformatf("t3_drain_wen_c%0d", cyc),
                          32'(bus.write_en), 1);
                check_val($sformatf("t3_drain_addr_c%0d", cyc),
                          32'(bus.wR_addr), 32'(10 + cyc / 9 - 1));
                check_val($sformatf("t3_drain_data_c%0d", cyc),
                          32'(bus.write_data), 32'hA000 + 32'(cyc / 9 - 1));
            end
            acc = bus.mem_valid && bus.mem_ready;
            step();
            if (acc) m++;
        end
        idle_inputs();
        @(negedge clk);
        check_val("t3_end_mem_ready", 32'(bus.mem_ready),  1);
        check_val("t3_end_wen",       32'(bus.write_en),   1);
        check_val("t3_end_waddr",     32'(bus.wR_addr),    1);
        check_val("t3_end_wdata",     32'(bus.write_data), 32'h012E);
        step();
        @(negedge clk);
        check_val("t3_idle_wen", 32'(bus.write_en), 0);

        // Load r9 buffered, then ALU r9: ALU held until the load issues.
        step();
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 16'h9999;
        @(negedge clk);
        check_val("t4_mem_ready", 32'(bus.mem_ready), 1);
        step();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 16'h5555;
        @(negedge clk);
        check_val("t4_alu_block", 32'(bus.alu_ready), 0);
        check_val("t4_wen_pre",   32'(bus.write_en),  0);
        step();
        @(negedge clk);
        check_val("t4_alu_open",  32'(bus.alu_ready),  1);
        check_val("t4_wen_mem",   32'(bus.write_en),   1);
        check_val("t4_addr_mem",  32'(bus.wR_addr),    9);
        check_val("t4_data_mem",  32'(bus.write_data), 32'h9999);
        step();
        idle_inputs();
        @(negedge clk);
        check_val("t4_wen_alu",   32'(bus.write_en),   1);
        check_val("t4_addr_alu",  32'(bus.wR_addr),    9);
        check_val("t4_data_alu",  32'(bus.write_data), 32'h5555);
        step();
        @(negedge clk);
        check_val("t4_idle_wen",  32'(bus.write_en), 0);

        // Three loads r20..r22 held back by ALU traffic, then reset.
        step();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd2; bus.alu_data = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1'b1;
            bus.mem_addr  = 5'(20 + i);
            bus.mem_data  = 16'hC000 + 16'(i);
            step();
        end
        bus.mem_valid = 1'b0;
        bus.rR1_addr  = 5'd20;
        @(negedge clk);
        check_val("t5_pre_mem_ready", 32'(bus.mem_ready),  1);
        check_val("t5_pre_pending",   32'(bus.r1_pending), 1);
        check_val("t5_pre_wen",       32'(bus.write_en),   1);
        reset = 1'b0;
        idle_inputs();
        #1;
        check_val("t5_rst_wen",       32'(bus.write_en),   0);
        check_val("t5_rst_waddr",     32'(bus.wR_addr),    0);
        check_val("t5_rst_mem_ready", 32'(bus.mem_ready),  1);
        check_val("t5_rst_pending",   32'(bus.r1_pending), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            check_val($sformatf("t5_no_write_%0d", i), 32'(bus.write_en), 0);
        end
        check_val("t5_post_pending", 32'(bus.r1_pending), 0);

        // ALU write to register 0
        bus.rR1_addr = 5'd0;
        step();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 16'h00AA;
        @(negedge clk);
        check_val("t6_alu_ready", 32'(bus.alu_ready), 1);
        step();
        idle_inputs();
        @(negedge clk);
`ifdef REGFILE_WB_R0_DISCARD_EN
        check_val("t6_r0_wen",     32'(bus.write_en),   0);
        check_val("t6_r0_pending", 32'(bus.r1_pending), 0);
`else
        check_val("t6_r0_wen",     32'(bus.write_en),   1);
        check_val("t6_r0_waddr",   32'(bus.wR_addr),    0);
        check_val("t6_r0_wdata",   32'(bus.write_data), 32'h00AA);
        check_val("t6_r0_pending", 32'(bus.r1_pending), 1);
`endif
        step();
        @(negedge clk);
        check_val("t6_idle_wen", 32'(bus.write_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-port controller for the 32x16 register file. It shares the single write port between two writeback sources: the ALU stage (priority) and the load/memory stage (buffered).
- Drives the register file's write_en / wR_addr / write_data from a registered output stage.
- Buffers memory writebacks in a small FIFO and blocks ALU writes that would reorder same-register writes.
- Reports pending writes against the two read addresses so the decode stage can stall.

Parameters:
- FIFO_DEPTH, 4, memory-writeback buffer entries; power of 2, >=2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before forced drain; >=1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  5  ALU destination register.
- alu_data  in  16  ALU result.
- alu_ready  out  1  ALU request is accepted this cycle (combinational).
- mem_valid  in  1  load writeback request.
- mem_addr  in  5  load destination register.
- mem_data  in  16  load data.
- mem_ready  out  1  FIFO not full (registered count).
- rR1_addr  in  5  decode-stage read address 1.
- rR2_addr  in  5  decode-stage read address 2.
- r1_pending  out  1  write to rR1_addr is buffered or in flight.
- r2_pending  out  1  same for rR2_addr.
- write_en  out  1  to register file, registered.
- wR_addr  out  5  to register file, registered.
- write_data  out  16  to register file, registered.

Behaviour:
- Reset (async, reset=0):
  - write_en=0, wR_addr=0, write_data=0.
  - FIFO empty, so mem_ready=1 after reset.
  - wait_cnt=0, FSM=NORMAL.
- Handshakes:
  - ALU transfer when alu_valid & alu_ready.
  - Memory transfer when mem_valid & mem_ready.
  - Memory transfers always enqueue; there is no direct path to the output.
- FSM states:
  - NORMAL:
    - alu_ready=1 unless alu_addr equals the addr of any valid FIFO entry (WAW ordering block).
    - Issue select: an accepted ALU write wins the output stage. Otherwise, if the FIFO is non-empty, pop the head into the output stage.
    - wait_cnt increments each cycle the FIFO is non-empty and its head is not popped; it clears on any pop.
    - When wait_cnt == STARVE_LIMIT-1 and the head is again not popped, go to DRAIN at that edge.
  - DRAIN:
    - alu_ready=0.
    - Head is popped unconditionally that cycle, wait_cnt cleared, next state NORMAL.
    - Exactly one entry is drained per DRAIN visit.
- Latency:
  - ALU accepted at edge N: write_en=1 with that addr/data during cycle N to N+1.
  - Memory enqueued at edge N: earliest write_en is cycle N+1 to N+2, i.e. 2-cycle minimum.
- Idle output: write_en=0 in any cycle with nothing issued. wR_addr/write_data hold their last values.
- FIFO boundaries:
  - mem_ready depends only on the registered occupancy.
  - When full, mem_ready=0 even if a pop occurs the same cycle; the slot is visible next cycle.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Pending flags:
  - rX_pending=1 if rR_X_addr matches any valid FIFO entry addr, or the output stage (write_en=1 and wR_addr match).
  - Pure combinational compare.
- Ordering: same-register writes reach the register file in acceptance order. A blocked ALU write waits until the matching entry has been popped.
- Reset mid-operation: buffered writes are discarded and no write_en pulse is generated.

Optional Feature:
- Macro: REGFILE_WB_R0_DISCARD_EN.
- Defined:
  - Writes to address 0 from either source are accepted (ready as normal) but never issued; write_en stays 0 for them.
  - Memory writes to address 0 are not enqueued.
  - Addr 0 never raises r1_pending/r2_pending and never blocks the ALU.
- Undefined: address 0 is an ordinary register.

Test Plan:
- Reset release, ALU write addr 3 data 0x1234 -> next cycle write_en=1, wR_addr=3, write_data=0x1234; following idle cycle write_en=0.
- Single mem write addr 7 data 0xBEEF with ALU idle, accepted edge N -> write_en=1 with addr 7 in cycle N+1 to N+2; r1_pending=1 for rR1_addr=7 from N to N+2.
- 5 mem writes back-to-back, ALU valid every cycle with addr 1, FIFO_DEPTH=4:
  - mem_ready=0 after the 4th enqueue.
  - After 8 blocked cycles alu_ready=0 for exactly one cycle and the head issues.
  - The pattern repeats until the FIFO drains.
- Mem write addr 9 buffered, then ALU write addr 9 -> alu_ready=0 until the mem write issues; register file sees mem data then ALU data, in that order.
- Assert reset for 1 cycle with 3 FIFO entries pending -> write_en=0, mem_ready=1, no buffered write ever appears.
- With REGFILE_WB_R0_DISCARD_EN: ALU write addr 0 -> alu_ready=1, write_en stays 0. Without the macro: write_en=1, wR_addr=0.
